// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, instruction field slices, ID/EX control struct and decode helpers.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam int OP_HI = 31, OP_LO = 26;
  localparam int RS_HI = 25, RS_LO = 21;
  localparam int RT_HI = 20, RT_LO = 16;
  localparam int RD_HI = 15, RD_LO = 11;
  localparam int IMM_HI = 15, IMM_LO = 0;
  localparam int FN_HI = 5, FN_LO = 0;
  typedef struct packed {
    logic       valid;
    logic [4:0] rs_addr;
    logic [4:0] rt_addr;
    logic [4:0] dest_addr;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_load;
  } id_ex_t;
  function automatic logic zero_ext(input logic [5:0] op);
    return op inside {OP_ANDI, OP_ORI, OP_XORI};
  endfunction
  // rt is a source operand only for R-type, stores and branches
  function automatic logic rt_used(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_SW, OP_BEQ, OP_BNE};
  endfunction
  function automatic logic [4:0] dest_sel(input logic [31:0] instr);
    return instr[OP_HI:OP_LO] == OP_RTYPE ? instr[RD_HI:RD_LO] :
           instr[OP_HI:OP_LO] == OP_JAL   ? 5'd31 : instr[RT_HI:RT_LO];
  endfunction
endpackage

// File: rtl/id_regfile.sv
// id_regfile: two-read one-write register file with write-first bypass; r0 and out-of-range read zero.
module id_regfile #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);
  logic [DATA_W-1:0] regs [1:NUM_REGS-1];
  always_ff @(posedge clk)
    for (int i = 1; i < NUM_REGS; i++)
      if (reset) regs[i] <= '0;
      else if (we && wa == 5'(i)) regs[i] <= wd;
  // only implemented nonzero entries match, so r0 and out-of-range addresses never bypass
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (ra1 == 5'(i)) rd1 = (we && wa == ra1) ? wd : regs[i];
      if (ra2 == 5'(i)) rd2 = (we && wa == ra2) ? wd : regs[i];
    end
  end
endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS decode with regfile, immediate extension, load-use hazard and valid/ready ID/EX register.
module id_stage import mips_pkg::*; #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [DATA_W-1:0] if_pc,
  output logic              id_ready,
  input  logic              flush,
  input  logic              ex_ready,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [4:0]        ex_rs_addr,
  output logic [4:0]        ex_rt_addr,
  output logic [4:0]        ex_dest_addr,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc,
  output logic [5:0]        ex_opcode,
  output logic [5:0]        ex_funct,
  output logic              ex_is_load,
  output logic [CNT_W-1:0]  stall_count
);
  id_ex_t ex_q, ex_d;
  logic [DATA_W-1:0] rs_q, rt_q, imm_q, pc_q, rs_rd, rt_rd, imm_d;
  logic [5:0] op;
  logic [4:0] rs, rt;
  logic [15:0] imm16;
  logic hazard, advance, stall;
  assign op    = if_instr[OP_HI:OP_LO];
  assign rs    = if_instr[RS_HI:RS_LO];
  assign rt    = if_instr[RT_HI:RT_LO];
  assign imm16 = if_instr[IMM_HI:IMM_LO];
  id_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rf (
    .clk(clk), .reset(reset), .we(wb_we), .wa(wb_addr), .wd(wb_data),
    .ra1(rs), .ra2(rt), .rd1(rs_rd), .rd2(rt_rd)
  );
  assign imm_d = zero_ext(op) ? {{(DATA_W-16){1'b0}}, imm16} : {{(DATA_W-16){imm16[15]}}, imm16};
  assign hazard = ex_q.valid && ex_q.is_load && ex_q.dest_addr != 5'd0 &&
                  (ex_q.dest_addr == rs || (rt_used(op) && ex_q.dest_addr == rt));
  assign stall    = if_valid && hazard;
  assign advance  = !ex_q.valid || ex_ready;
  assign id_ready = advance && !stall;
  always_comb begin
    ex_d.valid     = if_valid && !hazard;
    ex_d.rs_addr   = rs;
    ex_d.rt_addr   = rt;
    ex_d.dest_addr = dest_sel(if_instr);
    ex_d.opcode    = op;
    ex_d.funct     = if_instr[FN_HI:FN_LO];
    ex_d.is_load   = op == OP_LW;
  end
  always_ff @(posedge clk)
    if (reset) begin
      ex_q  <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      imm_q <= '0;
      pc_q  <= '0;
    end else if (flush) begin
      ex_q <= '0;
    end else if (advance) begin
      ex_q  <= ex_d;
      rs_q  <= rs_rd;
      rt_q  <= rt_rd;
      imm_q <= imm_d;
      pc_q  <= if_pc;
    end
  always_ff @(posedge clk)
    if (reset) stall_count <= '0;
    else if (stall && advance && !flush && stall_count != '1) stall_count <= stall_count + 1'b1;
  assign ex_valid     = ex_q.valid;
  assign ex_rs_addr   = ex_q.rs_addr;
  assign ex_rt_addr   = ex_q.rt_addr;
  assign ex_dest_addr = ex_q.dest_addr;
  assign ex_opcode    = ex_q.opcode;
  assign ex_funct     = ex_q.funct;
  assign ex_is_load   = ex_q.is_load;
  assign ex_rs_data   = rs_q;
  assign ex_rt_data   = rt_q;
  assign ex_imm       = imm_q;
  assign ex_pc        = pc_q;
endmodule

// File: doc/id_stage.md
# id_stage

Parametrised instruction-decode stage for the pipelined MIPS core, successor to the fixed 32-bit decode block. Sits between IF and EX. Holds the register file with write-first bypass, decodes and extends immediates, detects load-use hazards, and drives a valid/ready ID/EX pipeline register with stall, flush and back-pressure. Also keeps a saturating stall counter for performance inspection.

## Interface
- DATA_W, 32, datapath width; must be at least 32.
- NUM_REGS, 32, implemented registers, 2..32; register 0 reads zero.
- CNT_W, 16, stall counter width.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- if_valid  in  1  IF presents an instruction.
- if_instr  in  32  instruction word.
- if_pc  in  DATA_W  PC of the instruction.
- id_ready  out  1  ID accepts this cycle.
- flush  in  1  squash the instruction in ID and the ID/EX contents.
- ex_ready  in  1  EX accepts ID/EX contents.
- wb_we, wb_addr[4:0], wb_data[DATA_W]  in  write-back port.
- ex_valid  out  1  ID/EX holds a live instruction.
- ex_rs_data, ex_rt_data  out  DATA_W  operand values.
- ex_rs_addr, ex_rt_addr, ex_dest_addr  out  5  register addresses.
- ex_imm  out  DATA_W  extended immediate.
- ex_pc  out  DATA_W  registered PC.
- ex_opcode, ex_funct  out  6  instruction fields.
- ex_is_load  out  1  opcode is 0x23 (lw).
- stall_count  out  CNT_W  saturating count of hazard stalls.

## Operation
- Register file: NUM_REGS × DATA_W. Writes on the clk edge when wb_we is high, wb_addr is not 0 and wb_addr < NUM_REGS; all other writes are ignored. Reads of address 0 or of an address ≥ NUM_REGS return 0.
- Write-first bypass: if wb_we is high and wb_addr equals a read address, that read returns wb_data in the same cycle. Register 0 and out-of-range addresses are never bypassed.
- Immediate: opcodes 0x0C, 0x0D and 0x0E (andi, ori, xori) zero-extend instr[15:0] to DATA_W. All other opcodes sign-extend.
- ex_dest_addr:
  - opcode 0 → rd (instr[15:11]).
  - opcode 0x03 (jal) → 31.
  - otherwise → rt.
- Load-use hazard, combinational: asserted when ex_valid, ex_is_load, ex_dest_addr ≠ 0, and ex_dest_addr equals the rs or rt field of if_instr. The rt match counts only when opcode is 0 or opcode is 0x2B (sw) or 0x04/0x05 (beq/bne).
- advance = !ex_valid || ex_ready.
- id_ready = advance && !hazard. The hazard term applies only when if_valid is high.
- On an edge where advance is high:
  - ID/EX loads the decoded if_instr with ex_valid = if_valid && !hazard.
  - On a hazard, a bubble (ex_valid = 0) is inserted. IF must hold its instruction.
- When advance is low, ID/EX holds every field.
- flush has priority over everything except reset. ex_valid goes to 0 on the next edge regardless of ex_ready, and the current if_instr is dropped. The regfile write still occurs.
- stall_count increments on each edge where if_valid && hazard && advance && !flush. It saturates at 2^CNT_W − 1.

## Timing
- Latency: an instruction accepted at edge N appears on the ex_* outputs after edge N, i.e. one cycle later.
- A load-use hazard costs exactly one bubble cycle; id_ready is low for that cycle only.
- Reset (synchronous, any cycle, including mid-stall) leaves on the following cycle:
  - all registers 0;
  - ex_valid = 0 and all ex_* fields 0;
  - stall_count = 0.
  - id_ready is then 1.
- Reset and flush in the same cycle: reset wins.
- A write-back in the same cycle as a stalled read is visible on the retry through the bypass or the regfile.
- ID/EX fields change only on advance, flush or reset edges.

## Structure
- Shared package mips_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JAL, OP_ANDI, OP_ORI, OP_XORI;
  - field-slice localparams;
  - the id_ex_t struct of ID/EX fields.
- One sub-module, id_regfile, parametrised by DATA_W and NUM_REGS: two read ports, one write port, synchronous reset, write-first bypass.
- Hazard logic, decode and the pipeline register stay in id_stage.

## Test plan
- Write 0x0000_0001 to r10 via WB, then decode 0x002A_000A (rs=1, rt=10) with r1 = 0. Next cycle ex_rs_data = 0, ex_rt_data = 1, ex_dest_addr = 0, ex_valid = 1.
- Same-cycle bypass: wb_we with r5 = 0xDEAD_BEEF while decoding an instruction that reads r5 → ex_rs_data = 0xDEAD_BEEF. A WB to r0 reads back 0.
- Load-use:
  - Issue lw r8 (0x8C08_0000), then add r9 = r8 + r0.
  - Required: id_ready low for one cycle, one bubble (ex_valid = 0), then the add issues; stall_count = 1.
  - andi with imm 0xFFFF gives ex_imm = 0x0000_FFFF; addi with imm 0xFFFF gives 0xFFFF_FFFF.
- Back-pressure and flush:
  - With ex_ready = 0 for 3 cycles, ex_* stays stable and id_ready = 0.
  - flush during that hold → ex_valid = 0 next cycle.
- Parameters and reset:
  - With NUM_REGS = 16, a write to r20 is ignored and reads 0.
  - A reset asserted mid-stall clears every output and stall_count.
  - With CNT_W = 2, after 5 stalls stall_count = 3.
